mod_updown_counter: RTL
=======================

// Module: mod_updown_counter
// PURPOSE
//   Parametrised loadable up/down modulo counter; generalises the 4-bit
//   load/increment counter with zero flag. Adds programmable width and
//   modulus, count direction, enable, wrap or saturate mode, and
//   terminal-count/wrap flags. Used as a timebase/event counter in
//   control datapaths. All outputs registered, one cycle behind state.
// PARAMETERS
//   WIDTH     4              counter width in bits, >= 2
//   MAX_VAL   2**WIDTH-1     terminal value; count range 0..MAX_VAL,
//                            legal 1..2**WIDTH-1
//   SATURATE  0              0 = wrap at limits, 1 = hold at limits
// PORTS
//   clk       in   1      clock, all logic on posedge
//   rst       in   1      synchronous active-high reset
//   en        in   1      count enable
//   up        in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      load request, overrides en
//   load_val  in   WIDTH  value to load
//   count     out  WIDTH  registered copy of internal count
//   zero      out  1      registered: internal count was 0
//   at_max    out  1      registered: internal count was MAX_VAL
//   wrap      out  1      1-cycle pulse aligned with wrapped value on count
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Internal state cnt (WIDTH bits). Priority per edge: rst > load > en.
//   - rst=1: cnt=0, wrap_i=0, count=0, zero=0, at_max=0, wrap=0.
//     zero first rises on the edge after rst deasserts; rst mid-count
//     discards all state, including a pending wrap_i.
//   - load=1: cnt <= min(load_val, MAX_VAL); wrap_i <= 0. en/up ignored.
//   - en=1, up=1: cnt<MAX_VAL -> cnt+1. cnt==MAX_VAL -> SATURATE=0: cnt<=0,
//     wrap_i<=1; SATURATE=1: cnt holds, wrap_i<=0.
//   - en=1, up=0: cnt>0 -> cnt-1. cnt==0 -> SATURATE=0: cnt<=MAX_VAL,
//     wrap_i<=1; SATURATE=1: cnt holds, wrap_i<=0.
//   - en=0, load=0: cnt holds, wrap_i<=0.
//   - Output stage, every non-reset edge: count<=cnt; zero<=(cnt==0);
//     at_max<=(cnt==MAX_VAL); wrap<=wrap_i. Latency: a change to cnt
//     at edge k is visible on outputs after edge k+1.
//   - Arithmetic is WIDTH-bit; comparisons against MAX_VAL are exact, so a
//     non-power-of-2 modulus never exposes values above MAX_VAL on count.
//   - load_val > MAX_VAL: clamped to MAX_VAL, no error flag.
//   - Direction may change on any cycle; no dead cycle required.
//   - wrap never asserts in SATURATE=1 builds.
// TESTING
//   1 Reset: rst=1 two cycles then 0, en=0 -> count=0, zero=0 during
//     rst; zero=1 one cycle after release; wrap=0 throughout.
//   2 Wrap up, WIDTH=4 MAX_VAL=9: load 8, then en=1 up=1 -> count
//     8,9,0,1; wrap=1 only in the cycle count=0; at_max=1 when count=9.
//   3 Wrap down, MAX_VAL=9: load 1, en=1 up=0 -> count 1,0,9,8;
//     wrap=1 only in the cycle count=9; zero=1 when count=0.
//   4 Saturate, SATURATE=1 MAX_VAL=15: load 14, up 4 cycles -> count
//     14,15,15,15,15, wrap=0; then up=0 -> 14,13.
//   5 Load priority/clamp, MAX_VAL=9: load=1 en=1 load_val=12 -> count
//     9, at_max=1, no increment that cycle.
//   6 Reset mid-operation: counting up, assert rst in the cycle cnt
//     reaches MAX_VAL -> next edge count=0, wrap=0, no late wrap pulse.

Source files
------------

// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   Loadable up/down modulo counter for timebases and event counting.
//   The count range is 0..MAX_VAL. At each limit the counter either wraps
//   to the opposite limit or holds there, depending on SATURATE.
//   The outputs are registered, so they show the internal count one cycle
//   after it changes. The wrap flag is timed so that it is high in the same
//   cycle that the wrapped value appears on count.
// Ports
//   clk       clock; all logic runs on the rising edge
//   rst       synchronous active-high reset
//   en        count enable
//   up        direction: 1 = increment, 0 = decrement
//   load      load request; takes priority over en
//   load_val  value to load; values above MAX_VAL are clamped to MAX_VAL
//   count     registered copy of the internal count
//   zero      registered: internal count was 0
//   at_max    registered: internal count was MAX_VAL
//   wrap      one-cycle pulse, aligned with the wrapped value on count
module mod_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             at_max,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] count_q;
  logic             zero_q, at_max_q, wrap_out_q;

  logic at_top, at_bot;

  assign at_top = (cnt_q == MAX);
  assign at_bot = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!SATURATE) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!SATURATE) begin
          cnt_d  = MAX;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // Output stage samples the current state. Because wrap_q is registered
  // alongside the value it produced, the wrap pulse on the output lines up
  // with the wrapped count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      count_q    <= '0;
      zero_q     <= 1'b0;
      at_max_q   <= 1'b0;
      wrap_out_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      count_q    <= cnt_q;
      zero_q     <= at_bot;
      at_max_q   <= at_top;
      wrap_out_q <= wrap_q;
    end
  end

  assign count  = count_q;
  assign zero   = zero_q;
  assign at_max = at_max_q;
  assign wrap   = wrap_out_q;

endmodule
